modmul_stream_adapter: RTL and testbench
========================================

Name: modmul_stream_adapter

Overview:
- Streaming front/back end for the 256-bit modular multiplier core.
- Upstream side: assembles X and Y from a 32-bit valid/ready input stream and drives the core's operand, start and reset pins.
- Downstream side: waits for the core's done, applies a final conditional subtraction so the result is fully reduced, then emits it as a 32-bit valid/ready output stream.
- Includes a watchdog against a hung core.

Parameters:
- WIDTH, 256, operand/result width.
- WORD, 32, stream word width; WIDTH/WORD = 8 words per operand.
- MODULUS, 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF, prime used for the final correction.
- TIMEOUT, 4096, max cycles in WAIT before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- s_data  in  32  input operand word.
- s_valid  in  1  input word valid.
- s_ready  out  1  adapter accepts a word.
- m_data  out  32  result word.
- m_valid  out  1  result word valid.
- m_ready  in  1  sink accepts a word.
- m_last  out  1  marks 8th result word.
- core_X  out  256  operand X to core.
- core_Y  out  256  operand Y to core.
- core_start  out  1  one-cycle start pulse to core.
- core_rst  out  1  active-high core clear.
- core_Q  in  256  core result, value in [0, 2*MODULUS).
- core_done  in  1  core done level; stays high until core_rst.
- busy  out  1  high in any state except LOAD with word count 0.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, async): state=LOAD, word count=0, core_X=core_Y=0, core_start=0, core_rst=1, m_valid=0, m_last=0, m_data=0, s_ready=0, err_timeout=0, busy=0. core_rst is held high while reset is asserted.
- A transfer occurs when valid and ready are both high on a rising edge.
- LOAD:
  - s_ready=1, core_rst=0.
  - Words 0-7 fill core_X LSW first (word k -> bits [32k+31:32k]); words 8-15 fill core_Y the same way.
  - On acceptance of word 15 -> CLR.
  - s_valid low stalls without loss.
- CLR: s_ready=0, core_rst=1 for exactly one cycle (clears the core's sticky done) -> START.
- START: core_rst=0, core_start=1 for exactly one cycle; watchdog counter cleared -> WAIT.
- WAIT:
  - core_start=0. core_X/core_Y are held constant from CLR until the next LOAD completes.
  - When core_done is sampled 1, register core_Q -> CORR.
  - Watchdog increments each WAIT cycle. On reaching TIMEOUT with no done:
    - set err_timeout=1 (sticky until rst);
    - pulse core_rst one cycle;
    - discard the operation, produce no output;
    - go to LOAD with count 0.
  - done arriving in the same cycle the count reaches TIMEOUT: done wins, no error.
- CORR (1 cycle):
  - R = (Qreg >= MODULUS) ? Qreg - MODULUS : Qreg, computed in a 257-bit subtract; the borrow bit selects the result.
  - Qreg == MODULUS gives 0. core_Q >= 2*MODULUS is out of contract; R is then Qreg-MODULUS without checking.
  - -> SEND.
- SEND:
  - m_valid=1, m_data = R word j (LSW first), m_last=1 when j=7.
  - j advances only on m_ready handshake; m_data/m_last stable while m_valid=1 and m_ready=0.
  - After the word-7 handshake: m_valid=0 -> LOAD, count 0.
- Latency: word 15 accepted at edge t -> core_rst high cycle t+1, core_start high t+2. core_done sampled at edge d -> CORR cycle d+1, first m_valid cycle d+2.
- Throughput: one operation at a time; s_ready=0 outside LOAD, so no input is accepted during CLR..SEND.
- Reset mid-operation: all state discarded; the core is cleared through core_rst.
- All outputs registered; no combinational path from s_valid/m_ready to any output.

Test Plan:
- Basic: X=3, Y=5 as 16 words, s_valid always 1; model core returns core_Q=15 after 20 cycles -> core_rst pulse at t+1, core_start at t+2, m_data=15,0,0,0,0,0,0,0, m_last on 8th, busy low afterwards.
- Correction: core_Q = MODULUS+7 -> output 7. core_Q = MODULUS -> output all zeros. core_Q = MODULUS-1 -> passed unchanged.
- Backpressure: m_ready toggles 1,0,0,1,... and s_valid gaps of 3 cycles between words -> no word lost or duplicated; m_data stable while stalled; s_ready never high outside LOAD.
- Back-to-back ops with core_done left high between them -> the second op still waits for a fresh done after its core_rst pulse; results correct for both.
- Watchdog: TIMEOUT=64, core never asserts done -> err_timeout=1 at cycle 64 of WAIT, core_rst pulse, no m_valid. The next op completes normally and err_timeout stays 1.
- Async reset: drop rst mid-SEND after 3 words -> m_valid=0 immediately, core_rst=1. After release, a fresh 16-word load produces the correct result.

Source files
------------

// File: rtl/modmul_stream_adapter.sv
// Streaming adapter around the 256-bit modular multiplier core.
//
// Input side: collects 16 words from a 32-bit valid/ready stream. Words 0-7
// form X and words 8-15 form Y, least significant word first. It then clears
// the core, starts it, and waits for the core to raise done.
// Output side: takes the core result, which lies in [0, 2*MODULUS), applies one
// conditional subtraction so it is fully reduced, and sends the result as
// 8 words on a 32-bit valid/ready stream.
// A watchdog abandons the operation if the core never finishes.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   s_data/s_valid/s_ready    operand word input stream
//   m_data/m_valid/m_ready    result word output stream, m_last on word 7
//   core_X, core_Y            operands to the core, held from CLR to next load
//   core_start                one-cycle start pulse to the core
//   core_rst                  active-high core clear (high during reset)
//   core_Q, core_done         core result and sticky done level
//   busy                      high unless idle in LOAD with no words taken
//   err_timeout               sticky watchdog flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LOAD  | accepting operand words 0..15
// S_CLR   | core_rst pulse, clears the core's sticky done
// S_START | core_start pulse, watchdog loaded
// S_WAIT  | waiting for core_done, watchdog counting down
// S_ABORT | watchdog expired: core_rst pulse, operation dropped
// S_CORR  | final conditional subtraction of the captured result
// S_SEND  | emitting result words 0..7
module modmul_stream_adapter #(
    parameter int               WIDTH   = 256,
    parameter int               WORD    = 32,
    parameter logic [WIDTH-1:0] MODULUS =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF,
    parameter int               TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WORD-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WORD-1:0]  m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [WIDTH-1:0] core_X,
    output logic [WIDTH-1:0] core_Y,
    output logic             core_start,
    output logic             core_rst,
    input  logic [WIDTH-1:0] core_Q,
    input  logic             core_done,
    output logic             busy,
    output logic             err_timeout
);

    localparam int NWORDS = WIDTH / WORD;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLR,
        S_START,
        S_WAIT,
        S_ABORT,
        S_CORR,
        S_SEND
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [WD_W-1:0]  wd_cnt;
    logic [WIDTH-1:0] x_buf, y_buf, x_fill, y_fill;
    logic [WIDTH-1:0] q_reg, r_reg, r_corr;
    logic [WIDTH:0]   diff;
    logic             s_acc, m_acc, last_word, last_out;

    assign s_acc     = s_valid && s_ready;
    assign m_acc     = m_valid && m_ready;
    assign last_word = (cnt == CNT_W'(2 * NWORDS - 1));
    assign last_out  = (word_idx == IDX_W'(NWORDS - 1));

    // The borrow out of the extended subtraction means q_reg < MODULUS.
    assign diff   = {1'b0, q_reg} - {1'b0, MODULUS};
    assign r_corr = diff[WIDTH] ? q_reg : diff[WIDTH-1:0];

    // Operands are assembled in shadow buffers so core_X/core_Y only change
    // when a complete new pair has arrived.
    always_comb begin
        x_fill = x_buf;
        y_fill = y_buf;
        x_fill[int'(cnt[IDX_W-1:0]) * WORD +: WORD] = s_data;
        y_fill[int'(cnt[IDX_W-1:0]) * WORD +: WORD] = s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_LOAD: begin
                if (s_acc) begin
                    if (last_word) begin
                        state_nxt = S_CLR;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_CLR:   state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // done takes priority over an expiring watchdog
                if (core_done)         state_nxt = S_CORR;
                else if (wd_cnt == '0) state_nxt = S_ABORT;
            end
            S_ABORT: state_nxt = S_LOAD;
            S_CORR:  state_nxt = S_SEND;
            S_SEND: begin
                if (m_acc && last_out) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Outputs are registered from the next-state decode, so each one is valid
    // in the same cycle as the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            word_idx    <= '0;
            wd_cnt      <= '0;
            x_buf       <= '0;
            y_buf       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            core_X      <= '0;
            core_Y      <= '0;
            core_start  <= 1'b0;
            core_rst    <= 1'b1;
            s_ready     <= 1'b0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_data      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            s_ready    <= (state_nxt == S_LOAD);
            core_rst   <= (state_nxt == S_CLR) || (state_nxt == S_ABORT);
            core_start <= (state_nxt == S_START);
            busy       <= !((state_nxt == S_LOAD) && (cnt_nxt == '0));

            if (s_acc) begin
                if (!cnt[CNT_W-1]) x_buf <= x_fill;
                else               y_buf <= y_fill;
                if (last_word) begin
                    core_X <= x_buf;
                    core_Y <= y_fill;
                end
            end

            // watchdog is a down-counter; terminal count 0 ends the wait
            if (state == S_START) begin
                wd_cnt <= WD_W'(TIMEOUT - 1);
            end else if (state == S_WAIT) begin
                if (core_done)         q_reg  <= core_Q;
                else if (wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
            end

            if ((state == S_WAIT) && (state_nxt == S_ABORT)) err_timeout <= 1'b1;

            if (state == S_CORR) begin
                r_reg    <= r_corr;
                m_data   <= r_corr[WORD-1:0];
                m_valid  <= 1'b1;
                m_last   <= 1'b0;
                word_idx <= '0;
            end else if ((state == S_SEND) && m_acc) begin
                if (last_out) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end else begin
                    word_idx <= word_idx + 1'b1;
                    m_data   <= r_reg[(int'(word_idx) + 1) * WORD +: WORD];
                    m_last   <= (word_idx == IDX_W'(NWORDS - 2));
                end
            end
        end
    end

endmodule

// File: tb/tb_modmul_stream_adapter.sv
module tb_modmul_stream_adapter;

    localparam logic [255:0] MOD =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic [255:0] core_X, core_Y;
    logic [255:0] core_Q = '0;
    logic         core_start, core_rst;
    logic         core_done = 1'b0;
    logic         busy, err_timeout;

    always #5 clk = ~clk;

    modmul_stream_adapter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .core_X(core_X), .core_Y(core_Y), .core_start(core_start), .core_rst(core_rst),
        .core_Q(core_Q), .core_done(core_done), .busy(busy), .err_timeout(err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core model: done after lat_plan cycles, sticky until core_rst
    logic [255:0] q_plan = '0;
    int           lat_plan = 1;
    bit           never_done = 1'b0;
    int           lat_left = 0;
    bit           core_active = 1'b0;

    always @(posedge clk) begin
        if (core_rst) begin
            core_done   <= 1'b0;
            core_active <= 1'b0;
        end else if (core_start) begin
            core_active <= 1'b1;
            lat_left    <= lat_plan;
            core_Q      <= {8{32'hDEADBEEF}};
        end else if (core_active && !core_done && !never_done) begin
            if (lat_left <= 1) begin
                core_done <= 1'b1;
                core_Q    <= q_plan;
            end else begin
                lat_left <= lat_left - 1;
            end
        end
    end

    // ---------------- protocol monitor, sampled mid-cycle
    int          cyc = 0;
    int          done_rise_cyc = 0, mv_rise_cyc = 0, start_cyc = 0, err_rise_cyc = 0;
    int          mv_count = 0, stall_viol = 0, sready_viol = 0;
    logic        prev_mv = 0, prev_mr = 0, prev_ml = 0, prev_rst = 0, prev_done = 0, prev_err = 0;
    logic [31:0] prev_md = 0;
    bit          op_pending = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_mv   <= m_valid;
        prev_mr   <= m_ready;
        prev_md   <= m_data;
        prev_ml   <= m_last;
        prev_rst  <= rst;
        prev_done <= core_done;
        prev_err  <= err_timeout;
        if (rst && prev_rst) begin
            if (prev_mv && !prev_mr && (!m_valid || m_data !== prev_md || m_last !== prev_ml))
                stall_viol <= stall_viol + 1;
            if (s_ready && (op_pending || m_valid || core_start || core_rst))
                sready_viol <= sready_viol + 1;
        end
        if (core_done && !prev_done) done_rise_cyc <= cyc;
        if (m_valid && !prev_mv)     mv_rise_cyc   <= cyc;
        if (core_start)              start_cyc     <= cyc;
        if (err_timeout && !prev_err) err_rise_cyc <= cyc;
        if (m_valid)                 mv_count      <= mv_count + 1;
    end

    // ---------------- stimulus helpers
    logic [255:0] held_x = '0, held_y = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic ready_pat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic push_word(input logic [31:0] w);
        int budget = 200;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && budget > 0) begin
            step();
            budget--;
        end
        check("s_ready wait", s_ready, 1'b1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_words(input logic [255:0] x, input logic [255:0] y, input int gap);
        for (int k = 0; k < 16; k++) begin
            push_word(k < 8 ? x[32*k +: 32] : y[32*(k-8) +: 32]);
            if (k == 9) begin
                check("core_X held during load", core_X, held_x);
                check("core_Y held during load", core_Y, held_y);
            end
            if (k < 15) repeat (gap) step();
        end
        op_pending = 1'b1;
    endtask

    task automatic collect(input logic [255:0] r_exp, input int rmode, input int nwords);
        logic [31:0] got [8];
        logic        gl  [8];
        int j = 0;
        int c = 0;
        int budget = 600;
        m_ready = ready_pat(rmode, c);
        while (j < nwords && budget > 0) begin
            if (m_valid && m_ready) begin
                got[j] = m_data;
                gl[j]  = m_last;
                j++;
            end
            step();
            budget--;
            c++;
            m_ready = ready_pat(rmode, c);
        end
        m_ready = 1'b0;
        check("output word count", j, nwords);
        for (int i = 0; i < j; i++) begin
            check($sformatf("m_data word %0d", i), got[i], r_exp[32*i +: 32]);
            check($sformatf("m_last word %0d", i), gl[i], (i == 7));
        end
    endtask

    task automatic run_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] q,
                          input logic [255:0] r_exp, input int lat, input int gap,
                          input int rmode, input int nwords);
        q_plan   = q;
        lat_plan = lat;
        send_words(x, y, gap);
        check("CLR core_rst", core_rst, 1'b1);
        check("CLR core_start", core_start, 1'b0);
        check("CLR busy", busy, 1'b1);
        step();
        check("START core_rst", core_rst, 1'b0);
        check("START core_start", core_start, 1'b1);
        check("core_X", core_X, x);
        check("core_Y", core_Y, y);
        held_x = x;
        held_y = y;
        step();
        check("WAIT core_start", core_start, 1'b0);
        collect(r_exp, rmode, nwords);
        if (nwords == 8) begin
            check("done to m_valid latency", mv_rise_cyc - done_rise_cyc, 2);
            check("m_valid low after op", m_valid, 1'b0);
            check("busy low after op", busy, 1'b0);
            op_pending = 1'b0;
        end
    endtask

    typedef struct {
        logic [255:0] x, y, q, r;
        int lat, gap, rmode;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] x, y, q;
        int mvc0, budget;

        vecs[0] = '{256'd3, 256'd5, 256'd15, 256'd15, 20, 0, 0};
        vecs[1] = '{256'h1111_2222, 256'h3333_4444, MOD + 256'd7, 256'd7, 10, 0, 0};
        vecs[2] = '{256'hABCD << 100, 256'h55, MOD, 256'd0, 3, 3, 1};
        vecs[3] = '{256'd1, 256'd2, MOD - 256'd1, MOD - 256'd1, 1, 0, 1};
        vecs[4] = '{256'd7, 256'd9, {256{1'b1}},
                    256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000000, 30, 1, 0};
        vecs[5] = '{256'd0, 256'd0, 256'd0, 256'd0, 2, 0, 2};

        // reset values
        #2 rst = 1'b0;
        #1;
        check("reset s_ready", s_ready, 1'b0);
        check("reset m_valid", m_valid, 1'b0);
        check("reset m_last", m_last, 1'b0);
        check("reset m_data", m_data, 0);
        check("reset core_start", core_start, 1'b0);
        check("reset core_rst", core_rst, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset err_timeout", err_timeout, 1'b0);
        check("reset core_X", core_X, 0);
        check("reset core_Y", core_Y, 0);
        repeat (3) step();
        rst = 1'b1;
        step();

        // directed table, run back to back with done left high between ops
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r,
                   vecs[i].lat, vecs[i].gap, vecs[i].rmode, 8);

        // randomized against the reference: result is Q reduced modulo MOD
        for (int i = 0; i < 6; i++) begin
            x = rand256();
            y = rand256();
            q = rand256();
            run_op(x, y, q, q % MOD, $urandom_range(1, 40), $urandom_range(0, 3),
                   $urandom_range(0, 2), 8);
        end

        // watchdog: core never finishes
        never_done = 1'b1;
        mvc0 = mv_count;
        x = rand256();
        y = rand256();
        send_words(x, y, 0);
        step();
        held_x = x;
        held_y = y;
        budget = 200;
        while (!err_timeout && budget > 0) begin
            step();
            budget--;
        end
        check("watchdog err_timeout", err_timeout, 1'b1);
        check("watchdog core_rst pulse", core_rst, 1'b1);
        step();
        check("watchdog timing", err_rise_cyc - start_cyc, TO + 1);
        check("watchdog core_rst released", core_rst, 1'b0);
        check("watchdog back in LOAD", s_ready, 1'b1);
        check("watchdog busy", busy, 1'b0);
        check("watchdog no output", mv_count, mvc0);
        op_pending = 1'b0;
        never_done = 1'b0;
        q = rand256();
        run_op(rand256(), rand256(), q, q % MOD, 12, 0, 0, 8);
        check("err_timeout sticky", err_timeout, 1'b1);

        // async reset in the middle of SEND
        q = rand256();
        run_op(rand256(), rand256(), q, q % MOD, 5, 0, 0, 3);
        rst = 1'b0;
        #1;
        check("mid-SEND reset m_valid", m_valid, 1'b0);
        check("mid-SEND reset core_rst", core_rst, 1'b1);
        check("mid-SEND reset s_ready", s_ready, 1'b0);
        check("mid-SEND reset err_timeout", err_timeout, 1'b0);
        check("mid-SEND reset busy", busy, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        op_pending = 1'b0;
        held_x = '0;
        held_y = '0;
        step();
        x = rand256();
        y = rand256();
        q = MOD + 256'd1234;
        run_op(x, y, q, 256'd1234, 8, 1, 1, 8);

        check("stall stability", stall_viol, 0);
        check("s_ready only in LOAD", sready_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
